// File: rtl/result_scan_ctrl.sv
// End-of-poll result sequencer: locks voting, reads every vote counter once,
// tracks the running maximum and hands winner/count/tie to the display unit.
module result_scan_ctrl #(
  parameter int NUM_CAND = 3,
  parameter int CAND_W   = 4,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              vote_lock,
  output logic              rd_en,
  output logic [CAND_W-1:0] rd_addr,
  input  logic [CNT_W-1:0]  rd_data,
  output logic              result_valid,
  input  logic              result_ack,
  output logic [CAND_W-1:0] winner_candidate,
  output logic [CNT_W-1:0]  winner_vote_count,
  output logic              tie,
  output logic              no_votes
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [CAND_W-1:0] LAST_IDX = CAND_W'(NUM_CAND - 1);

  state_t              state_q, state_d;
  logic [CAND_W-1:0]   idx_q, idx_d;
  logic                cmp_vld_q, cmp_vld_d;
  logic [CAND_W-1:0]   cmp_idx_q, cmp_idx_d;
  logic [CNT_W-1:0]    max_q, max_d;
  logic [CAND_W-1:0]   win_q, win_d;
  logic                tie_q, tie_d;
  logic [CAND_W-1:0]   res_win_q, res_win_d;
  logic [CNT_W-1:0]    res_cnt_q, res_cnt_d;
  logic                res_tie_q, res_tie_d;
  logic                res_nov_q, res_nov_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start) state_d = SCAN;
      end
      SCAN: begin
        idx_d = idx_q + CAND_W'(1);
        if (idx_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE: if (result_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Compare stage: runs one cycle behind the read strobe, matching rd_data latency.
  always_comb begin
    cmp_vld_d = (state_q == SCAN);
    cmp_idx_d = idx_q;
    max_d     = max_q;
    win_d     = win_q;
    tie_d     = tie_q;
    if (cmp_vld_q) begin
      if (cmp_idx_q == '0) begin
        max_d = rd_data;
        win_d = '0;
        tie_d = 1'b0;
      end else if (rd_data > max_q) begin
        max_d = rd_data;
        win_d = cmp_idx_q;
        tie_d = 1'b0;
      end else if (rd_data == max_q) begin
        win_d = cmp_idx_q;
        tie_d = 1'b1;
      end
    end
  end

  // Result registers capture the final compare as DRAIN retires, then hold.
  always_comb begin
    res_win_d = res_win_q;
    res_cnt_d = res_cnt_q;
    res_tie_d = res_tie_q;
    res_nov_d = res_nov_q;
    if (state_q == DRAIN) begin
      res_win_d = win_d;
      res_cnt_d = max_d;
      res_tie_d = tie_d;
      res_nov_d = (max_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= '0;
      res_win_q <= '0;
      res_cnt_q <= '0;
      res_tie_q <= 1'b0;
      res_nov_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_idx_q <= cmp_idx_d;
      res_win_q <= res_win_d;
      res_cnt_q <= res_cnt_d;
      res_tie_q <= res_tie_d;
      res_nov_q <= res_nov_d;
    end
  end

  // Running-max datapath needs no reset: the first sample of every scan reloads it.
  always_ff @(posedge clk) begin
    max_q <= max_d;
    win_q <= win_d;
    tie_q <= tie_d;
  end

  assign busy              = (state_q != IDLE);
  assign vote_lock         = (state_q != IDLE);
  assign rd_en             = (state_q == SCAN);
  assign rd_addr           = (state_q == SCAN) ? idx_q : '0;
  assign result_valid      = (state_q == DONE);
  assign winner_candidate  = res_win_q;
  assign winner_vote_count = res_cnt_q;
  assign tie               = res_tie_q;
  assign no_votes          = res_nov_q;

endmodule
